// File: rtl/jtag_cmd_sequencer_if.sv
// Command/response valid-ready bundle between a host and the JTAG sequencer.
// The host drives the master modport; the sequencer uses the slave modport.
interface jtag_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_cmd_sequencer.sv
// JTAG master: one command per handshake, bits shifted at clk/(2*TCK_DIV), tdo captured on tck rise.
// Scan results wait in RESP until consumed; commands are refused while busy or a response is pending.
module jtag_cmd_sequencer #(
  parameter int TCK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtag_cmd_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TCK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [5:0]    len_q, len_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   cap_q, cap_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [5:0]    acc_len;
  logic          last_bit;
  logic          finish;

  // Returns {tms, tdi} for bit idx of a command.
  function automatic logic [1:0] bit_drive(input logic [1:0] op, input logic [5:0] len,
                                           input logic [31:0] data, input logic [4:0] idx);
    logic last;
    last = ({1'b0, idx} == (len - 6'd1));
    case (op)
      2'd0:    bit_drive = {(idx < 5'd5), 1'b0};
      2'd1:    bit_drive = {data[idx], 1'b0};
      2'd2:    bit_drive = {1'b0, data[idx]};
      default: bit_drive = {last, data[idx]};
    endcase
  endfunction

  assign acc_len  = (bus.cmd_op == 2'd0) ? 6'd6 :
                    ((bus.cmd_len > 6'd32) ? 6'd32 : bus.cmd_len);
  assign last_bit = ({1'b0, bit_q} == (len_q - 6'd1));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    finish      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          len_d   = acc_len;
          data_d  = bus.cmd_data;
          cap_d   = '0;
          bit_d   = '0;
          cnt_d   = CNT_LOAD;
          tck_d   = 1'b0;
          state_d = S_LOW;
          if (acc_len != 6'd0) begin
            {tms_d, tdi_d} = bit_drive(bus.cmd_op, acc_len, bus.cmd_data, 5'd0);
          end else begin
            {tms_d, tdi_d} = 2'b00;
          end
        end
      end
      S_LOW: begin
        // A zero-length command spends one cycle here and completes with no pulses.
        if (len_q == 6'd0) begin
          finish = 1'b1;
        end else if (cnt_q == '0) begin
          tck_d        = 1'b1;
          cap_d[bit_q] = tdo;
          cnt_d        = CNT_LOAD;
          state_d      = S_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          tck_d = 1'b0;
          cnt_d = CNT_LOAD;
          if (last_bit) begin
            finish = 1'b1;
          end else begin
            bit_d          = bit_q + 5'd1;
            {tms_d, tdi_d} = bit_drive(op_q, len_q, data_q, bit_q + 5'd1);
            state_d        = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      tck_d = 1'b0;
      tms_d = 1'b0;
      tdi_d = 1'b0;
      if (op_q[1]) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = cap_q;
        state_d     = S_RESP;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);
  assign tck           = tck_q;
  assign tms           = tms_q;
  assign tdi           = tdi_q;
endmodule
